mask_reduce_ctrl: RTL and testbench
===================================

# mask_reduce_ctrl

Sequencer for a per-bit mask-and-reduce datapath: it applies a programmable per-bit force/invert mask to each word of an input stream, AND-reduces the masked word to one bit, and accumulates run statistics. It sits between a word source, which supplies a valid/ready stream, and a consumer of per-word reduction bits. A start/done handshake frames each run of a fixed word count, and mask configuration is locked while a run is active.

## Interface
- WIDTH, 4, lane width in bits
- COUNT_W, 8, width of word count and hit counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe; ignored while busy
- cfg_force_en  in  WIDTH  per-bit force enable
- cfg_force_val  in  WIDTH  per-bit forced value
- cfg_invert  in  WIDTH  per-bit invert (applies only to unforced bits)
- start  in  1  begin run; sampled only in IDLE
- num_words  in  COUNT_W  words in the run; latched on start
- in_valid  in  1  input word valid
- in_data  in  WIDTH  input word
- in_ready  out  1  controller accepts a word
- res_valid  out  1  per-word result valid, one-cycle pulse
- res_bit  out  1  AND-reduce of the masked word
- busy  out  1  run in progress
- done  out  1  run complete, one-cycle pulse
- out_all  out  1  AND of all res_bit values in the run
- out_hits  out  COUNT_W  count of res_bit==1 in the run

## Operation
- Masked bit i: if force_en[i], the bit is force_val[i]; otherwise it is in_data[i] ^ invert[i]. res_bit = &masked.
- Config registers update on cfg_we when not busy. Reset sets all three to 0, which is pass-through.
- FSM states:
  - IDLE: start with num_words≠0 → RUN. start with num_words==0 → DONE.
  - RUN: in_ready = 1 while remaining ≠ 0. On accepting the last word → DRAIN.
  - DRAIN: one cycle → DONE.
  - DONE: one cycle → IDLE.
- On start: remaining ← num_words, out_all ← 1, out_hits ← 0.
- On each handshake (in_valid & in_ready): remaining decrements.
- On each res_valid: out_all &= res_bit. out_hits increments when res_bit==1. out_hits cannot overflow, because it is bounded by num_words.
- start is ignored when not in IDLE. cfg_we is ignored while busy; the mask used during a run is the one in place at start.
- out_all and out_hits hold their values until the next start.

## Timing
- Reset values: in_ready 0, res_valid 0, res_bit 0, busy 0, done 0, out_all 1, out_hits 0. FSM resets to IDLE and remaining to 0.
- Result latency: a word accepted at cycle t gives res_valid=1 and res_bit at t+1. Back-to-back acceptance gives back-to-back results.
- Run timing, last word accepted at t:
  - t+1: final res_valid (DRAIN).
  - t+2: done=1, and out_all/out_hits are final (DONE).
  - t+3: busy=0 (IDLE).
- busy is high from the cycle after start through the DONE cycle inclusive.
- Zero-word run: start at t gives done at t+1 with out_all=1 and out_hits=0.
- in_valid low during RUN stalls the run with no timeout. in_data is don't-care when in_valid is low.
- rst_n low mid-run aborts immediately: all outputs return to reset values and the partial run is lost.

## Configuration
- MASK_REDUCE_STATS_EN defined: the hit counter is implemented and out_hits behaves as specified.
- MASK_REDUCE_STATS_EN not defined: no hit counter register exists and out_hits is constant 0. All other behaviour is unchanged.

## Structure
- Package mask_reduce_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE), 2 bits;
  - the default WIDTH and COUNT_W localparams.
- Sub-module mask_lane is purely combinational. It takes in_data, force_en, force_val and invert, and produces the masked word and its reduce bit. The controller registers its output.

## Test plan
- Reset then idle → out_all=1, out_hits=0, busy=0, in_ready=0; cfg reads back as 0.
- cfg force_en=4'b1000, force_val=4'b1000, invert=4'b0101; num_words=4 with words 0x2, 0xA, 0x3, 0xF, in_valid held high → res_bit sequence 1,1,0,0; done at last accept +2; out_hits=2, out_all=0.
- Pass-through cfg, num_words=3, words 0xF,0xF,0xF with in_valid toggling 1,0 → 3 res_valid pulses only on accepts; out_all=1, out_hits=3.
- start with num_words=0 → done one cycle later, busy high exactly 1 cycle, out_all=1, out_hits=0, in_ready never high.
- cfg_we with invert=4'b1111 mid-run, plus start asserted mid-run → both ignored; results match the pre-run mask; a second start after IDLE uses the new cfg only if it was rewritten in IDLE.
- Assert rst_n low after 2 of 5 words → all outputs at reset values next cycle; a following run of 1 word 0xF (pass-through) gives out_all=1, out_hits=1.

Source files
------------

// File: rtl/mask_reduce_pkg.sv
// Shared types and default sizes for the mask-and-reduce sequencer.
package mask_reduce_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mask_reduce_ctrl_mask_lane.sv
// Combinational per-bit force/invert mask followed by an AND-reduce.
module mask_lane
  import mask_reduce_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] force_en,
  input  logic [WIDTH-1:0] force_val,
  input  logic [WIDTH-1:0] invert,
  output logic [WIDTH-1:0] masked,
  output logic             red
);

  // A forced bit ignores both the data and its invert setting.
  always_comb begin
    masked = '0;
    for (int i = 0; i < WIDTH; i++) begin
      masked[i] = force_en[i] ? force_val[i] : (in_data[i] ^ invert[i]);
    end
  end

  assign red = &masked;

endmodule

// File: rtl/mask_reduce_ctrl.sv
// Run sequencer for the mask-and-reduce lane with locked config and run stats.
// Define MASK_REDUCE_STATS_EN to build the hit counter; otherwise out_hits is tied to 0.
module mask_reduce_ctrl
  import mask_reduce_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [WIDTH-1:0]   cfg_force_en,
  input  logic [WIDTH-1:0]   cfg_force_val,
  input  logic [WIDTH-1:0]   cfg_invert,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_words,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               res_valid,
  output logic               res_bit,
  output logic               busy,
  output logic               done,
  output logic               out_all,
  output logic [COUNT_W-1:0] out_hits
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   force_en_q, force_val_q, invert_q;
  logic [COUNT_W-1:0] remaining_q;
  logic               res_valid_q, res_bit_q, all_q;
  logic [WIDTH-1:0]   masked_word;
  logic               lane_red, word_hit, start_run, accept;

  mask_lane #(.WIDTH(WIDTH)) u_lane (
    .in_data   (in_data),
    .force_en  (force_en_q),
    .force_val (force_val_q),
    .invert    (invert_q),
    .masked    (masked_word),
    .red       (lane_red)
  );

  assign word_hit  = lane_red & (&masked_word);
  assign start_run = (state_q == IDLE) && start;
  assign accept    = in_valid && in_ready;

  assign in_ready  = (state_q == RUN) && (remaining_q != '0);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign res_valid = res_valid_q;
  assign res_bit   = res_bit_q;
  assign out_all   = all_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_words != '0) ? RUN : DONE;
      RUN:     if (accept && (remaining_q == COUNT_W'(1))) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Mask is frozen for the whole run, including the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_en_q  <= '0;
      force_val_q <= '0;
      invert_q    <= '0;
    end else if (cfg_we && !busy) begin
      force_en_q  <= cfg_force_en;
      force_val_q <= cfg_force_val;
      invert_q    <= cfg_invert;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      all_q       <= 1'b1;
    end else begin
      res_valid_q <= accept;
      res_bit_q   <= accept & word_hit;
      if (start_run) begin
        remaining_q <= num_words;
        all_q       <= 1'b1;
      end else begin
        if (accept) remaining_q <= remaining_q - COUNT_W'(1);
        if (res_valid_q) all_q <= all_q & res_bit_q;
      end
    end
  end

`ifdef MASK_REDUCE_STATS_EN
  logic [COUNT_W-1:0] hits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q <= '0;
    end else if (start_run) begin
      hits_q <= '0;
    end else if (res_valid_q && res_bit_q) begin
      hits_q <= hits_q + COUNT_W'(1);
    end
  end

  assign out_hits = hits_q;
`else
  assign out_hits = '0;
`endif

endmodule

// File: tb/tb_mask_reduce_ctrl.sv
// Self-checking bench for mask_reduce_ctrl against a word-level reference model.
module tb_mask_reduce_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_we = 1'b0;
  logic [W-1:0]  cfg_force_en = '0, cfg_force_val = '0, cfg_invert = '0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, res_valid, res_bit, busy, done, out_all;
  logic [CW-1:0] out_hits;

  mask_reduce_ctrl #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_force_en(cfg_force_en),
    .cfg_force_val(cfg_force_val), .cfg_invert(cfg_invert), .start(start),
    .num_words(num_words), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .res_valid(res_valid), .res_bit(res_bit), .busy(busy),
    .done(done), .out_all(out_all), .out_hits(out_hits)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]  m_fe = '0, m_fv = '0, m_inv = '0;
  logic [W-1:0]  word_q[$];
  logic          obs_res[$];
  int            done_cyc, last_acc, busy_cnt, done_cnt, pulse_err;
  bit            ready_seen, finished;
  logic          done_all;
  logic [CW-1:0] done_hits;

  // Reference: forced bits take force_val, the rest are data xor invert; hit when all ones.
  function automatic logic ref_bit(logic [W-1:0] w);
    logic [W-1:0] m;
    m = (m_fe & m_fv) | (~m_fe & (w ^ m_inv));
    return (m == {W{1'b1}});
  endfunction

  function automatic logic [63:0] pack_exp();
    logic [63:0] r = '0;
    foreach (word_q[i]) r[i] = ref_bit(word_q[i]);
    return r;
  endfunction

  function automatic logic [63:0] pack_obs();
    logic [63:0] r = '0;
    foreach (obs_res[i]) r[i] = obs_res[i];
    return r;
  endfunction

  function automatic int exp_ones();
    int c = 0;
    foreach (word_q[i]) if (ref_bit(word_q[i])) c++;
    return c;
  endfunction

  function automatic logic [CW-1:0] exp_hits(int h);
`ifdef MASK_REDUCE_STATS_EN
    return CW'(h);
`else
    return (h > 0) ? '0 : '0;
`endif
  endfunction

  task automatic cfg_write(input logic [W-1:0] fe, input logic [W-1:0] fv, input logic [W-1:0] inv);
    cfg_we = 1'b1; cfg_force_en = fe; cfg_force_val = fv; cfg_invert = inv;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_force_en = '0; cfg_force_val = '0; cfg_invert = '0;
    m_fe = fe; m_fv = fv; m_inv = inv;
  endtask

  // Drives one run (mode 0: valid held, 1: valid toggling, 2: random) and records observations.
  task automatic do_run(input int n, input int mode);
    bit v, tog, prev_acc;
    int sent, cyc;
    obs_res.delete();
    done_cyc = -1; last_acc = -1; busy_cnt = 0; done_cnt = 0; pulse_err = 0;
    ready_seen = 0; finished = 0; sent = 0; tog = 0; prev_acc = 0;
    start = 1'b1; num_words = CW'(n);
    @(posedge clk); #1;
    start = 1'b0; cyc = 0;
    for (int k = 0; k < 400; k++) begin
      if (res_valid !== prev_acc) pulse_err++;
      if (res_valid) obs_res.push_back(res_bit);
      if (busy) busy_cnt++;
      if (in_ready) ready_seen = 1;
      if (done) begin done_cnt++; done_cyc = cyc; done_all = out_all; done_hits = out_hits; end
      if (!busy) begin finished = 1; break; end
      case (mode)
        0:       v = 1;
        1:       begin v = !tog; tog = !tog; end
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      if (sent >= word_q.size()) v = 0;
      in_valid = v;
      if (v) in_data = word_q[sent];
      else   in_data = W'($urandom);
      prev_acc = v && in_ready;
      if (prev_acc) begin last_acc = cyc; sent++; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2; rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++; if ({in_ready, res_valid, res_bit, busy, done, out_all} !== 6'b000001) begin
      n_err++; $display("FAIL reset_flags got %b want 000001", {in_ready, res_valid, res_bit, busy, done, out_all});
    end
    n_vec++; if (out_hits !== '0) begin n_err++; $display("FAIL reset_hits got %0d want 0", out_hits); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    m_fe = '0; m_fv = '0; m_inv = '0;
    word_q = '{4'hF, 4'hE};
    do_run(2, 0);
    n_vec++; if (pack_obs() !== 64'b01 || obs_res.size() != 2) begin
      n_err++; $display("FAIL reset_cfg_passthru got %b want 01", pack_obs());
    end
  endtask

  task automatic test_masked_run();
    cfg_write(4'b1000, 4'b1000, 4'b0101);
    word_q = '{4'h2, 4'hA, 4'h3, 4'hF};
    do_run(4, 0);
    n_vec++; if (!finished) begin n_err++; $display("FAIL masked_timeout got busy want idle"); end
    n_vec++; if (pack_obs() !== 64'b0011 || pack_obs() !== pack_exp() || obs_res.size() != 4) begin
      n_err++; $display("FAIL masked_bits got %b want 0011", pack_obs());
    end
    n_vec++; if (done_cyc != last_acc + 2 || done_cnt != 1) begin
      n_err++; $display("FAIL masked_done got cyc %0d cnt %0d want cyc %0d cnt 1", done_cyc, done_cnt, last_acc + 2);
    end
    n_vec++; if (done_all !== 1'b0 || done_hits !== exp_hits(2)) begin
      n_err++; $display("FAIL masked_stats got all %b hits %0d want all 0 hits %0d", done_all, done_hits, exp_hits(2));
    end
    n_vec++; if (pulse_err != 0) begin n_err++; $display("FAIL masked_pulses got %0d bad want 0", pulse_err); end
  endtask

  task automatic test_stall();
    cfg_write('0, '0, '0);
    word_q = '{4'hF, 4'hF, 4'hF};
    do_run(3, 1);
    n_vec++; if (!finished || pulse_err != 0 || obs_res.size() != 3) begin
      n_err++; $display("FAIL stall_pulses got %0d results %0d bad want 3 results 0 bad", obs_res.size(), pulse_err);
    end
    n_vec++; if (done_cyc != last_acc + 2) begin
      n_err++; $display("FAIL stall_done got %0d want %0d", done_cyc, last_acc + 2);
    end
    n_vec++; if (done_all !== 1'b1 || done_hits !== exp_hits(3)) begin
      n_err++; $display("FAIL stall_stats got all %b hits %0d want all 1 hits %0d", done_all, done_hits, exp_hits(3));
    end
  endtask

  task automatic test_zero_words();
    word_q.delete();
    do_run(0, 0);
    n_vec++; if (!finished || done_cyc != 0 || busy_cnt != 1 || done_cnt != 1) begin
      n_err++; $display("FAIL zero_timing got done %0d busy %0d want done 0 busy 1", done_cyc, busy_cnt);
    end
    n_vec++; if (ready_seen || obs_res.size() != 0) begin
      n_err++; $display("FAIL zero_ready got ready %0d results %0d want 0 0", ready_seen, obs_res.size());
    end
    n_vec++; if (done_all !== 1'b1 || done_hits !== '0) begin
      n_err++; $display("FAIL zero_stats got all %b hits %0d want all 1 hits 0", done_all, done_hits);
    end
  endtask

  task automatic test_cfg_lock();
    cfg_write('0, '0, '0);
    word_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    fork
      do_run(4, 0);
      begin
        repeat (2) @(posedge clk);
        #2; cfg_we = 1'b1; cfg_invert = '1; start = 1'b1;
        @(posedge clk);
        #2; cfg_we = 1'b0; cfg_invert = '0; start = 1'b0;
      end
    join
    n_vec++; if (pack_obs() !== pack_exp() || obs_res.size() != 4 || done_cnt != 1) begin
      n_err++; $display("FAIL lock_run got %b want %b", pack_obs(), pack_exp());
    end
    @(posedge clk); #1;
    word_q = '{4'hF, 4'h0};
    do_run(2, 0);
    n_vec++; if (pack_obs() !== 64'b01 || pack_obs() !== pack_exp()) begin
      n_err++; $display("FAIL lock_second got %b want 01", pack_obs());
    end
    cfg_write('0, '0, 4'b1111);
    word_q = '{4'h0, 4'hF};
    do_run(2, 0);
    n_vec++; if (pack_obs() !== 64'b01 || pack_obs() !== pack_exp()) begin
      n_err++; $display("FAIL lock_rewrite got %b want 01", pack_obs());
    end
  endtask

  task automatic test_reset_abort();
    int acc = 0;
    cfg_write(4'b0001, 4'b0000, 4'b0000);
    start = 1'b1; num_words = CW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && acc < 2; k++) begin
      in_valid = 1'b1; in_data = 4'hF;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    n_vec++; if (acc != 2 || res_valid !== 1'b1) begin
      n_err++; $display("FAIL abort_setup got accepts %0d valid %b want 2 1", acc, res_valid);
    end
    rst_n = 1'b0; in_valid = 1'b0; #1;
    n_vec++; if ({in_ready, res_valid, res_bit, busy, done, out_all} !== 6'b000001 || out_hits !== '0) begin
      n_err++; $display("FAIL abort_outputs got %b hits %0d want 000001 hits 0",
                        {in_ready, res_valid, res_bit, busy, done, out_all}, out_hits);
    end
    m_fe = '0; m_fv = '0; m_inv = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    word_q = '{4'hF};
    do_run(1, 0);
    n_vec++; if (done_all !== 1'b1 || done_hits !== exp_hits(1) || pack_obs() !== 64'b1) begin
      n_err++; $display("FAIL abort_rerun got all %b hits %0d bits %b want all 1 hits %0d bits 1",
                        done_all, done_hits, pack_obs(), exp_hits(1));
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      int n;
      logic ea;
      cfg_write(W'($urandom), W'($urandom), W'($urandom));
      n = $urandom_range(1, 12);
      word_q.delete();
      for (int i = 0; i < n; i++) word_q.push_back(W'($urandom));
      do_run(n, 2);
      ea = (exp_ones() == n);
      n_vec++; if (!finished || pulse_err != 0 || obs_res.size() != n || pack_obs() !== pack_exp()) begin
        n_err++; $display("FAIL rand_bits run %0d got %b want %b", r, pack_obs(), pack_exp());
      end
      n_vec++; if (done_cyc != last_acc + 2 || done_cnt != 1) begin
        n_err++; $display("FAIL rand_done run %0d got %0d want %0d", r, done_cyc, last_acc + 2);
      end
      n_vec++; if (done_all !== ea || done_hits !== exp_hits(exp_ones())) begin
        n_err++; $display("FAIL rand_stats run %0d got all %b hits %0d want all %b hits %0d",
                          r, done_all, done_hits, ea, exp_hits(exp_ones()));
      end
      @(posedge clk); #1;
      n_vec++; if (out_all !== ea || out_hits !== exp_hits(exp_ones())) begin
        n_err++; $display("FAIL rand_hold run %0d got all %b hits %0d want all %b", r, out_all, out_hits, ea);
      end
    end
  endtask

  initial begin
    test_reset();
    test_masked_run();
    test_stall();
    test_zero_words();
    test_cfg_lock();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
